// File: rtl/uart_tx13.sv
// uart_tx13 - serial transmitter for 13-bit SECDED codewords.
// Frame: one start bit (low), 13 data bits LSB first, STOP_BITS stop bits (high).
// The codeword is captured on accept, so the upstream encoder may change
// tx_data freely once tx_ready drops. tx is driven straight from a flop.
module uart_tx13 #(
   parameter int CLKS_PER_BIT = 434,
   parameter int STOP_BITS    = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tx_valid,
   input  logic [12:0] tx_data,
   output logic        tx_ready,
   output logic        tx,
   output logic        tx_done
);

   localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_TC   = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]        LAST_BIT  = 4'd12;
   localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [3:0]        bit_q, bit_d;
   logic              stop_q, stop_d;
   logic [12:0]       shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              done_q, done_d;
   logic              baud_tc;

   assign baud_tc  = (baud_q == BAUD_TC);
   assign tx_ready = (state_q == IDLE);
   assign tx       = tx_q;
   assign tx_done  = done_q;

   // Next-state logic: bit-period timing, data shifting and line level.
   // The line level is computed from the next state so the registered tx
   // changes on the same edge as the state.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      shift_d = shift_q;
      done_d  = 1'b0;
      tx_d    = 1'b1;

      case (state_q)
         IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            stop_d = 1'b0;
            if (tx_valid) begin
               state_d = START;
               shift_d = tx_data;
            end
         end
         START: begin
            if (baud_tc) begin
               baud_d  = '0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         DATA: begin
            if (baud_tc) begin
               baud_d  = '0;
               // every completed bit period moves the next bit into position 0
               shift_d = shift_q >> 1;
               if (bit_q == LAST_BIT) begin
                  state_d = STOP;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         STOP: begin
            if (baud_tc) begin
               baud_d = '0;
               if (stop_q == STOP_LAST) begin
                  state_d = IDLE;
                  stop_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  stop_d = stop_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            baud_d  = '0;
            bit_d   = '0;
            stop_d  = 1'b0;
         end
      endcase

      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   // State and datapath registers; reset aborts any frame and idles the line high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: doc/uart_tx13.md
# uart_tx13

Serial transmitter for 13-bit Hamming SECDED codewords. It accepts a parallel codeword from the Hamming encoder stage over a valid/ready handshake and shifts it out on the UART line. Each frame is one start bit, 13 data bits sent LSB first, and STOP_BITS stop bits. It is the stage directly downstream of the encoder and drives the physical TX pin.

## Interface
- CLKS_PER_BIT, default 434: clock cycles per bit period (50 MHz / 115200). Legal values ≥ 2.
- STOP_BITS, default 1: number of stop bits. Legal values 1 or 2.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- tx_valid  input  1  tx_data holds a codeword to send.
- tx_data  input  13  codeword; bit 0 (p1) is transmitted first, bit 12 (p_total) last.
- tx_ready  output  1  block can accept a codeword; equals (state == IDLE).
- tx  output  1  serial line, registered; idles high.
- tx_done  output  1  one-cycle pulse when a frame's final stop bit completes.

## Operation
- States and transitions:
  - IDLE → START on accept.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → STOP after 13 × CLKS_PER_BIT cycles.
  - STOP → IDLE after STOP_BITS × CLKS_PER_BIT cycles.
- Accept means tx_valid && tx_ready sampled at a rising edge. On accept, tx_data is copied into an internal 13-bit shift register.
- After accept, changes on tx_data have no effect on the frame in progress.
- tx_valid is ignored outside IDLE. There is no queue, and a request made while busy is not remembered.
- Line levels by state:
  - START: tx = 0.
  - DATA: tx = shift register bit 0; the register shifts right once per completed bit period.
  - STOP: tx = 1.
  - IDLE: tx = 1.
- Baud counter: counts 0..CLKS_PER_BIT−1, width $clog2(CLKS_PER_BIT). It wraps to 0 at each bit boundary and is held at 0 in IDLE.
- Bit counter: 4 bits, counts 0..12 in DATA. The DATA → STOP transition happens when the bit counter is 12 and the baud counter is at its terminal count.
- Stop counting covers STOP_BITS × CLKS_PER_BIT cycles in total.
- Reset (rst_n low) at any time, including mid-frame, takes effect immediately without waiting for a clock edge:
  - state = IDLE; tx = 1; tx_done = 0; tx_ready = 1.
  - Counters and the shift register are cleared.
  - The aborted frame is not resumed.

## Timing
- Reset values: tx = 1, tx_ready = 1, tx_done = 0.
- Cycle numbering: let the accept edge be cycle 0.
  - tx falls to 0 in cycle 1 (registered output).
  - Data bit i occupies cycles 1 + (1+i)·CLKS_PER_BIT through (2+i)·CLKS_PER_BIT.
  - The stop bit(s) end at cycle (14+STOP_BITS)·CLKS_PER_BIT.
- In cycle (14+STOP_BITS)·CLKS_PER_BIT + 1:
  - state is IDLE, tx_ready = 1, and tx_done is high for exactly this one cycle;
  - a new accept is allowed in this same cycle.
- Minimum frame spacing, measured accept to accept, is (14+STOP_BITS)·CLKS_PER_BIT + 1 cycles. The gap inserts one extra idle-high cycle between back-to-back frames.
- tx_ready is combinational from state and goes low in cycle 1.
- tx never glitches: it is driven directly from a flop.

## Test plan
All scenarios use CLKS_PER_BIT=4 and STOP_BITS=1 unless stated.
- Reset: hold rst_n low 3 cycles with random tx_valid/tx_data → tx=1, tx_ready=1, tx_done=0 throughout; no frame starts after release while tx_valid=0.
- Single frame, tx_data=13'h0A5B, accept at cycle 0:
  - tx is low for cycles 1–4;
  - then data bits 1,1,0,1,1,0,1,0,0,1,0,1,0 each for 4 cycles (cycles 5–56);
  - high for cycles 57–60;
  - tx_done=1 only in cycle 61, together with tx_ready=1.
- Back-to-back: tx_valid held high with 13'h1FFF, then 13'h0000 → second start bit falls in cycle 62; exactly one idle-high cycle between frames; tx_done pulses once per frame.
- Busy request ignored: pulse tx_valid with 13'h1234 at cycle 20 of a frame started with 13'h0001 → the line carries only 13'h0001; no second frame; tx_data changes mid-frame do not alter the output.
- Mid-frame reset: assert rst_n low at cycle 30 → tx=1 and tx_ready=1 immediately, with no clock edge required; after release, a new accept of 13'h0F0F produces a clean full frame.
- STOP_BITS=2: tx_data=13'h1555 → stop high for 8 cycles; tx_done in cycle 65.
